w_stage_grf: RTL and testbench

Writeback-stage consumer of the M/W pipeline register. It decodes the instruction held in W, selects the writeback source (ALU result, memory read data, or link address), and commits the value into a 32×32 general register file. It also serves the D-stage read ports with same-cycle write-through bypass and keeps a retired-instruction counter. It sits between the M/W register outputs and the D-stage operand logic, and exports the W write triple to the hazard and forward units.

---
 rtl/w_stage_grf.sv | 193 +++++++++++++++++++
 tb/tb_w_stage_grf.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/w_stage_grf.sv
// w_stage_grf: writeback stage and general register file.
// Decodes the instruction held in the W pipeline register, selects the value
// to write back (ALU result, memory read data or link address) and commits it
// into the 32x32 register file. The D stage reads two operands
// combinationally. A W-stage write in the same cycle is forwarded straight to
// the read ports, so no W->D stall is needed. A counter tracks retired
// (non-bubble) instructions.
//
// Interface contract: there is no valid/ready handshake. Every cycle the W
// inputs describe exactly one instruction, or a bubble when W_Instr is 0. The
// write triple (W_we, W_wa, W_wd) is a pure function of those inputs. The
// register file takes the write on the next rising clock edge.
module w_stage_grf #(
   parameter int CNT_W    = 32,
   parameter int LINK_OFS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      W_PC,
   input  logic [31:0]      W_Instr,
   input  logic [31:0]      W_ALUAns,
   input  logic [31:0]      W_DMRD,
   input  logic             W_b_jump,
   input  logic [4:0]       D_rs_addr,
   input  logic [4:0]       D_rt_addr,
   output logic [31:0]      D_rs_data,
   output logic [31:0]      D_rt_data,
   output logic             W_we,
   output logic [4:0]       W_wa,
   output logic [31:0]      W_wd,
   output logic [CNT_W-1:0] retire_cnt
);

   // Writeback source selected by the decoder.
   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_MEM  = 2'd2,
      WB_LINK = 2'd3
   } wb_src_e;

   // Opcode and function values recognised in W.
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] FN_ADDU    = 6'b100001;
   localparam logic [5:0] FN_SUBU    = 6'b100011;
   localparam logic [4:0] RT_BGEZAL  = 5'b10001;
   localparam logic [4:0] REG_RA     = 5'd31;

   // Instruction fields.
   logic [5:0]  op;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;

   // Raw decode results, before the $0 filter is applied.
   wb_src_e     dec_src;
   logic [4:0]  dec_wa;
   logic        dec_cond_ok;
   logic [31:0] link_val;
   logic [31:0] dec_wd;
   logic        dec_wr;

   // Architectural state.
   logic [31:0] regs [1:31];

   assign op    = W_Instr[31:26];
   assign rt    = W_Instr[20:16];
   assign rd    = W_Instr[15:11];
   assign funct = W_Instr[5:0];

   // Link arithmetic wraps modulo 2^32.
   assign link_val = W_PC + 32'(LINK_OFS);

   // Choose the writeback source and destination from the opcode fields.
   always_comb begin
      dec_src     = WB_NONE;
      dec_wa      = 5'd0;
      dec_cond_ok = 1'b1;
      unique case (op)
         OP_SPECIAL: begin
            if (funct == FN_ADDU || funct == FN_SUBU) begin
               dec_src = WB_ALU;
               dec_wa  = rd;
            end
         end
         OP_ORI, OP_LUI: begin
            dec_src = WB_ALU;
            dec_wa  = rt;
         end
         OP_LW: begin
            dec_src = WB_MEM;
            dec_wa  = rt;
         end
         OP_JAL: begin
            dec_src = WB_LINK;
            dec_wa  = REG_RA;
         end
         OP_REGIMM: begin
            if (rt == RT_BGEZAL) begin
               dec_src     = WB_LINK;
               dec_wa      = REG_RA;
               dec_cond_ok = W_b_jump;
            end
         end
         default: begin
            dec_src = WB_NONE;
            dec_wa  = 5'd0;
         end
      endcase
   end

   // Mux the writeback data. Non-writing decodes drive zero.
   always_comb begin
      dec_wd = 32'd0;
      unique case (dec_src)
         WB_ALU:  dec_wd = W_ALUAns;
         WB_MEM:  dec_wd = W_DMRD;
         WB_LINK: dec_wd = link_val;
         default: dec_wd = 32'd0;
      endcase
   end

   // An untaken bgezal reports no destination and no data, like any
   // non-writing instruction.
   assign dec_wr = (dec_src != WB_NONE) && dec_cond_ok;

   // A write aimed at $0 is suppressed, and the address is driven to 0 so
   // the hazard logic never sees it as a producer.
   always_comb begin
      W_we = 1'b0;
      W_wa = 5'd0;
      W_wd = 32'd0;
      if (dec_wr) begin
         W_wd = dec_wd;
         if (dec_wa != 5'd0) begin
            W_we = 1'b1;
            W_wa = dec_wa;
         end
      end
   end

   // Register file storage. $0 has no storage.
   // Reset clears $1..$31 asynchronously and discards any write on that edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= 32'd0;
         end
      end else if (W_we) begin
         regs[W_wa] <= W_wd;
      end
   end

   // Read port A: $0 reads 0, then the W bypass, then storage.
   always_comb begin
      D_rs_data = 32'd0;
      if (D_rs_addr == 5'd0) begin
         D_rs_data = 32'd0;
      end else if (W_we && (D_rs_addr == W_wa)) begin
         D_rs_data = W_wd;
      end else begin
         D_rs_data = regs[D_rs_addr];
      end
   end

   // Read port B: same priority as port A.
   always_comb begin
      D_rt_data = 32'd0;
      if (D_rt_addr == 5'd0) begin
         D_rt_data = 32'd0;
      end else if (W_we && (D_rt_addr == W_wa)) begin
         D_rt_data = W_wd;
      end else begin
         D_rt_data = regs[D_rt_addr];
      end
   end

   // Count every non-bubble instruction that leaves W. The counter wraps
   // naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retire_cnt <= '0;
      end else if (W_Instr != 32'd0) begin
         retire_cnt <= retire_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_w_stage_grf.sv
// tb_w_stage_grf: directed test of the writeback stage and register file.
// Expected values are pushed into a queue as each step is driven. They are
// popped and compared when the DUT output is sampled.
module tb_w_stage_grf;

   localparam int CNT_W = 4;

   // Clock and reset.
   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      W_PC;
   logic [31:0]      W_Instr;
   logic [31:0]      W_ALUAns;
   logic [31:0]      W_DMRD;
   logic             W_b_jump;
   logic [4:0]       D_rs_addr;
   logic [4:0]       D_rt_addr;
   logic [31:0]      D_rs_data;
   logic [31:0]      D_rt_data;
   logic             W_we;
   logic [4:0]       W_wa;
   logic [31:0]      W_wd;
   logic [CNT_W-1:0] retire_cnt;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   w_stage_grf #(.CNT_W(CNT_W), .LINK_OFS(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .W_PC       (W_PC),
      .W_Instr    (W_Instr),
      .W_ALUAns   (W_ALUAns),
      .W_DMRD     (W_DMRD),
      .W_b_jump   (W_b_jump),
      .D_rs_addr  (D_rs_addr),
      .D_rt_addr  (D_rt_addr),
      .D_rs_data  (D_rs_data),
      .D_rt_data  (D_rt_data),
      .W_we       (W_we),
      .W_wa       (W_wa),
      .W_wd       (W_wd),
      .retire_cnt (retire_cnt)
   );

   // Driver tasks.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_w(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] alu, input logic [31:0] dmrd,
                          input logic bj);
      W_Instr  = instr;
      W_PC     = pc;
      W_ALUAns = alu;
      W_DMRD   = dmrd;
      W_b_jump = bj;
   endtask

   // Scoreboard tasks.
   task automatic sb_push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic sb_check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   // Instruction encodings.
   function automatic logic [31:0] i_ori(input logic [4:0] t, input logic [15:0] imm);
      return {6'b001101, 5'd0, t, imm};
   endfunction
   function automatic logic [31:0] i_lui(input logic [4:0] t, input logic [15:0] imm);
      return {6'b001111, 5'd0, t, imm};
   endfunction
   function automatic logic [31:0] i_lw(input logic [4:0] t, input logic [15:0] imm);
      return {6'b100011, 5'd1, t, imm};
   endfunction
   function automatic logic [31:0] i_rtype(input logic [4:0] d, input logic [5:0] fn);
      return {6'b000000, 5'd1, 5'd2, d, 5'd0, fn};
   endfunction
   function automatic logic [31:0] i_jal();
      return {6'b000011, 26'h40};
   endfunction
   function automatic logic [31:0] i_bgezal();
      return {6'b000001, 5'd3, 5'b10001, 16'd4};
   endfunction

   // Directed sequence.
   initial begin
      reset = 1'b0;
      drive_w(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      D_rs_addr = 5'd0;
      D_rt_addr = 5'd0;
      repeat (3) tick();
      reset = 1'b1;

      // Reset state: every register reads 0 and the counter is 0.
      for (int r = 1; r < 32; r++) begin
         D_rs_addr = 5'(r);
         #1;
         sb_push(32'd0);
         sb_check($sformatf("reset_reg%0d", r), D_rs_data);
      end
      sb_push(32'd0);
      sb_check("reset_cnt", 32'(retire_cnt));
      tick();

      // ori $5: same-cycle write triple and bypass on both ports.
      drive_w(i_ori(5'd5, 16'h1234), 32'h1000, 32'h1234, 32'h0, 1'b0);
      D_rs_addr = 5'd5;
      D_rt_addr = 5'd5;
      #1;
      sb_push(32'd1);      sb_check("ori_we", 32'(W_we));
      sb_push(32'd5);      sb_check("ori_wa", 32'(W_wa));
      sb_push(32'h1234);   sb_check("ori_wd", W_wd);
      sb_push(32'h1234);   sb_check("ori_rs_bypass", D_rs_data);
      sb_push(32'h1234);   sb_check("ori_rt_bypass", D_rt_data);
      sb_push(32'd0);      sb_check("ori_cnt_before", 32'(retire_cnt));
      tick();
      drive_w(32'd0, 32'h0, 32'h0, 32'h0, 1'b0);
      #1;
      sb_push(32'h1234);   sb_check("ori_rs_stored", D_rs_data);
      sb_push(32'd1);      sb_check("ori_cnt_after", 32'(retire_cnt));

      // lw $7 takes the memory data, not the ALU result.
      drive_w(i_lw(5'd7, 16'h40), 32'h1004, 32'h40, 32'hDEAD_BEEF, 1'b0);
      D_rs_addr = 5'd7;
      #1;
      sb_push(32'hDEAD_BEEF); sb_check("lw_wd", W_wd);
      tick();
      drive_w(32'd0, 32'h0, 32'h0, 32'h0, 1'b0);
      #1;
      sb_push(32'hDEAD_BEEF); sb_check("lw_stored", D_rs_data);

      // addu to $0 is suppressed and $0 still reads 0.
      drive_w(i_rtype(5'd0, 6'b100001), 32'h1008, 32'h55, 32'h0, 1'b0);
      D_rs_addr = 5'd0;
      #1;
      sb_push(32'd0);      sb_check("addu0_we", 32'(W_we));
      sb_push(32'd0);      sb_check("addu0_wa", 32'(W_wa));
      sb_push(32'd0);      sb_check("addu0_rs", D_rs_data);
      tick();
      #1;
      sb_push(32'd0);      sb_check("addu0_rs_after", D_rs_data);

      // subu $12 and lui $3 each write their ALU result.
      drive_w(i_rtype(5'd12, 6'b100011), 32'h100C, 32'h77, 32'h0, 1'b0);
      #1;
      sb_push(32'd12);     sb_check("subu_wa", 32'(W_wa));
      tick();
      drive_w(i_lui(5'd3, 16'hABCD), 32'h1010, 32'hABCD_0000, 32'h0, 1'b0);
      D_rs_addr = 5'd12;
      D_rt_addr = 5'd3;
      #1;
      sb_push(32'h77);        sb_check("subu_stored", D_rs_data);
      sb_push(32'hABCD_0000); sb_check("lui_bypass", D_rt_data);
      tick();

      // jr writes nothing and drives zeros.
      drive_w(i_rtype(5'd0, 6'b001000), 32'h1014, 32'h99, 32'h0, 1'b0);
      #1;
      sb_push(32'd0);      sb_check("jr_we", 32'(W_we));
      sb_push(32'd0);      sb_check("jr_wd", W_wd);
      tick();

      // jal, then bgezal untaken and taken.
      D_rs_addr = 5'd31;
      drive_w(i_jal(), 32'h3000, 32'h0, 32'h0, 1'b0);
      #1;
      sb_push(32'h3008);   sb_check("jal_wd", W_wd);
      tick();
      drive_w(i_bgezal(), 32'h3010, 32'h0, 32'h0, 1'b0);
      #1;
      sb_push(32'd0);      sb_check("bgezal_nt_we", 32'(W_we));
      sb_push(32'h3008);   sb_check("bgezal_nt_ra", D_rs_data);
      tick();
      #1;
      sb_push(32'h3008);   sb_check("bgezal_nt_ra_after", D_rs_data);
      drive_w(i_bgezal(), 32'h3010, 32'h0, 32'h0, 1'b1);
      #1;
      sb_push(32'd1);      sb_check("bgezal_t_we", 32'(W_we));
      sb_push(32'h3018);   sb_check("bgezal_t_wd", W_wd);
      tick();
      drive_w(32'd0, 32'h0, 32'h0, 32'h0, 1'b0);
      #1;
      sb_push(32'h3018);   sb_check("bgezal_t_ra", D_rs_data);

      // The link value wraps modulo 2^32.
      drive_w(i_jal(), 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
      #1;
      sb_push(32'h4);      sb_check("jal_wrap_wd", W_wd);
      tick();

      // Mid-operation reset: $9=AA, then reset with ori $9,BB held in W.
      drive_w(i_ori(5'd9, 16'h00AA), 32'h2000, 32'hAA, 32'h0, 1'b0);
      tick();
      drive_w(i_ori(5'd9, 16'h00BB), 32'h2004, 32'hBB, 32'h0, 1'b0);
      D_rs_addr = 5'd9;
      #1;
      sb_push(32'hBB);     sb_check("midrst_bypass", D_rs_data);
      #1;
      reset = 1'b0;
      #1;
      sb_push(32'hBB);     sb_check("midrst_wd_in_reset", W_wd);
      sb_push(32'd0);      sb_check("midrst_cnt", 32'(retire_cnt));
      tick();
      drive_w(32'd0, 32'h0, 32'h0, 32'h0, 1'b0);
      #1;
      sb_push(32'd0);      sb_check("midrst_reg9", D_rs_data);
      reset = 1'b1;
      tick();
      sb_push(32'd0);      sb_check("midrst_reg9_after", D_rs_data);
      sb_push(32'd0);      sb_check("midrst_cnt_after", 32'(retire_cnt));

      // Counter wrap: 15 instructions, 3 bubbles, then 2 instructions.
      for (int k = 1; k <= 20; k++) begin
         if (k >= 16 && k <= 18) begin
            drive_w(32'd0, 32'h0, 32'h0, 32'h0, 1'b0);
         end else begin
            drive_w($urandom_range(32'hFFFF_FFFF, 32'd1), 32'h4000, $urandom, $urandom, 1'b0);
         end
         tick();
         if (k <= 15)      sb_push(32'(k));
         else if (k <= 18) sb_push(32'd15);
         else              sb_push(32'(k - 19));
         sb_check($sformatf("wrap_cnt_step%0d", k), 32'(retire_cnt));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
